// File: rtl/cacheline_adapter_types.sv
// Shared constants and state encoding for the cache-line <-> burst-memory adapter.
package cacheline_adapter_types;

  localparam int BEATS    = 4;
  localparam int BEAT_W   = 64;
  localparam int LINE_W   = 256;
  localparam int OFFSET_W = 5;
  localparam int CNT_W    = $clog2(BEATS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR      = 3'd3,
    S_RESP    = 3'd4
  } adapter_state_t;

endpackage

// File: rtl/cacheline_adapter.sv
// Services one 256-bit cache-line read or write as a four-beat 64-bit memory burst,
// holding a single outstanding transaction and pulsing dfp_resp on completion.
module cacheline_adapter
  import cacheline_adapter_types::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          dfp_addr,
  input  logic                 dfp_read,
  input  logic                 dfp_write,
  input  logic [LINE_W-1:0]    dfp_wdata,
  output logic [LINE_W-1:0]    dfp_rdata,
  output logic                 dfp_resp,
  output logic [31:0]          bmem_addr,
  output logic                 bmem_read,
  output logic                 bmem_write,
  output logic [BEAT_W-1:0]    bmem_wdata,
  input  logic                 bmem_ready,
  input  logic [31:0]          bmem_raddr,
  input  logic [BEAT_W-1:0]    bmem_rdata,
  input  logic                 bmem_rvalid,
  output adapter_state_t       dbg_state
);

  // Handshake: the cache holds dfp_read/dfp_write until the one-cycle dfp_resp.
  // Memory accepts bmem_read or write beat 0 only in a cycle with bmem_ready=1;
  // write beats 1-3 follow on consecutive cycles, read beats arrive on bmem_rvalid.

  adapter_state_t      state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [LINE_W-1:0]   line_q;
  logic [31:0]         addr_q;
  logic [7:0]          beat_lsb;

  // Offset bits and the read-beat address tag carry no information here.
  logic unused_inputs;
  assign unused_inputs = ^{dfp_addr[OFFSET_W-1:0], bmem_raddr};

  assign beat_lsb = {cnt_q, 6'd0};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
      addr_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          // A simultaneous read is dropped in favour of the write.
          if (dfp_write) begin
            addr_q  <= {dfp_addr[31:OFFSET_W], {OFFSET_W{1'b0}}};
            line_q  <= dfp_wdata;
            state_q <= S_WR;
          end else if (dfp_read) begin
            addr_q  <= {dfp_addr[31:OFFSET_W], {OFFSET_W{1'b0}}};
            state_q <= S_RD_REQ;
          end
        end
        S_RD_REQ: begin
          if (bmem_ready) begin
            cnt_q   <= '0;
            state_q <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (bmem_rvalid) begin
            line_q[beat_lsb +: BEAT_W] <= bmem_rdata;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(BEATS - 1)) begin
              state_q <= S_RESP;
            end
          end
        end
        S_WR: begin
          if ((cnt_q != '0) || bmem_ready) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(BEATS - 1)) begin
              state_q <= S_RESP;
            end
          end
        end
        S_RESP: begin
          // Requests are still asserted this cycle, so nothing is sampled here.
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign dfp_resp   = (state_q == S_RESP);
  assign dfp_rdata  = line_q;
  assign bmem_addr  = addr_q;
  assign bmem_read  = (state_q == S_RD_REQ);
  // The write strobe marks accepted beats only, so a stalled beat 0 is not strobed.
  assign bmem_write = (state_q == S_WR) && ((cnt_q != '0) || bmem_ready);
  assign bmem_wdata = line_q[beat_lsb +: BEAT_W];
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed and randomized checks of cacheline_adapter against a latency/data model of a line transfer.
module tb_cacheline_adapter;
  import cacheline_adapter_types::*;

  logic           clk;
  logic           rst;
  logic [31:0]    dfp_addr;
  logic           dfp_read;
  logic           dfp_write;
  logic [255:0]   dfp_wdata;
  logic [255:0]   dfp_rdata;
  logic           dfp_resp;
  logic [31:0]    bmem_addr;
  logic           bmem_read;
  logic           bmem_write;
  logic [63:0]    bmem_wdata;
  logic           bmem_ready;
  logic [31:0]    bmem_raddr;
  logic [63:0]    bmem_rdata;
  logic           bmem_rvalid;
  adapter_state_t dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_resp = 0;

  cacheline_adapter dut (
    .clk(clk), .rst(rst),
    .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
    .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid), .dbg_state(dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // The cache must never raise both requests at once.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      assert (!(dfp_read && dfp_write)) else begin
        errors++;
        $error("FAIL protocol: read and write requested together");
      end
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Quiet cycles: no requests, memory noise on the return path must be ignored.
  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      dfp_read    = 1'b0;
      dfp_write   = 1'b0;
      bmem_ready  = 1'($urandom);
      bmem_rvalid = 1'($urandom);
      bmem_rdata  = {$urandom, $urandom};
      #1;
      chk("idle_read", bmem_read, 1'b0);
      chk("idle_write", bmem_write, 1'b0);
      chk("idle_resp", dfp_resp, 1'b0);
    end
  endtask

  // Line read: memory accepts the command rd cycles late, beat k arrives at cycle tk.
  task automatic do_read(input logic [31:0] addr, input logic [255:0] line, input int rd,
                         input int t0, input int t1, input int t2, input int t3);
    int tt[4];
    int resp;
    int k;
    logic [31:0] al;
    tt = '{t0, t1, t2, t3};
    resp = t3 + 1;
    al = addr & 32'hFFFF_FFE0;
    k = 0;
    for (int c = 0; c <= resp; c++) begin
      @(negedge clk);
      dfp_write   = 1'b0;
      dfp_read    = 1'b1;
      dfp_addr    = addr;
      dfp_wdata   = {8{$urandom}};
      bmem_ready  = (c < 1 + rd) ? 1'b0 : ((c == 1 + rd) ? 1'b1 : 1'($urandom));
      bmem_raddr  = al;
      bmem_rvalid = 1'b0;
      bmem_rdata  = {$urandom, $urandom};
      if (k < 4 && c == tt[k]) begin
        bmem_rvalid = 1'b1;
        bmem_rdata  = line[k*64 +: 64];
        k++;
      end
      #1;
      chk("rd_bmem_read", bmem_read, (c >= 1 && c <= 1 + rd));
      chk("rd_bmem_write", bmem_write, 1'b0);
      chk("rd_resp", dfp_resp, (c == resp));
      if (c >= 1 && c <= 1 + rd) chk("rd_addr", bmem_addr, al);
      if (c == resp) begin
        chk("rd_rdata", dfp_rdata, line);
        last_resp = cyc;
      end
    end
  endtask

  // Line write: memory holds off beat 0 for w cycles, then beats stream back-to-back.
  task automatic do_write(input logic [31:0] addr, input logic [255:0] line, input int w);
    int resp;
    logic [31:0] al;
    logic exp_wr;
    resp = 5 + w;
    al = addr & 32'hFFFF_FFE0;
    for (int c = 0; c <= resp; c++) begin
      @(negedge clk);
      dfp_read    = 1'b0;
      dfp_write   = 1'b1;
      dfp_addr    = addr;
      dfp_wdata   = line;
      bmem_ready  = (c >= 1 && c < 1 + w) ? 1'b0 : ((c == 1 + w) ? 1'b1 : 1'($urandom));
      bmem_rvalid = 1'($urandom);
      bmem_rdata  = {$urandom, $urandom};
      #1;
      exp_wr = (c >= 1 + w) && (c <= 4 + w);
      chk("wr_bmem_write", bmem_write, exp_wr);
      chk("wr_bmem_read", bmem_read, 1'b0);
      chk("wr_resp", dfp_resp, (c == resp));
      if (exp_wr) begin
        chk("wr_wdata", bmem_wdata, line[(c-1-w)*64 +: 64]);
        chk("wr_addr", bmem_addr, al);
      end
      if (c == resp) begin
        chk("wr_rdata", dfp_rdata, line);
        last_resp = cyc;
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"}, dbg_state, S_IDLE);
    chk({tag, "_resp"}, dfp_resp, 1'b0);
    chk({tag, "_read"}, bmem_read, 1'b0);
    chk({tag, "_write"}, bmem_write, 1'b0);
    chk({tag, "_rdata"}, dfp_rdata, 256'h0);
    chk({tag, "_addr"}, bmem_addr, 32'h0);
    chk({tag, "_wdata"}, bmem_wdata, 64'h0);
  endtask

  logic [255:0] line;
  logic [31:0]  addr;
  int r1, rd, t0, t1, t2, t3;

  initial begin
    rst = 1'b1; dfp_addr = '0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = '0;
    bmem_ready = 1'b0; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_outputs("reset");
    idle(2);

    // Read of 0x1234 at minimum latency.
    line = {{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}};
    do_read(32'h0000_1234, line, 0, 2, 3, 4, 5);
    idle(1);

    // Write of 0x40 with bmem_ready held low for 3 cycles.
    line = {{4{16'hDDDD}}, {4{16'hCCCC}}, {4{16'hBBBB}}, {4{16'hAAAA}}};
    do_write(32'h0000_0040, line, 3);
    idle(1);

    // Read with gaps between beats.
    line = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    do_read(32'hABCD_EF1F, line, 0, 3, 6, 7, 10);
    idle(2);

    // Eviction then fill, back-to-back.
    line = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    do_write(32'h0000_2000, line, 0);
    r1 = last_resp;
    line = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    do_read(32'h0000_3000, line, 0, 2, 3, 4, 5);
    chk("b2b_gap", 32'(last_resp - r1), 32'd7);
    idle(3);

    // Reset after beat 1 of a read; late beats must be ignored.
    @(negedge clk);
    dfp_read = 1'b1; dfp_addr = 32'h0000_5000; bmem_ready = 1'b0; bmem_rvalid = 1'b0;
    @(negedge clk);
    bmem_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bmem_rvalid = 1'b1; bmem_rdata = {$urandom, $urandom}; bmem_raddr = 32'h0000_5000;
    end
    @(negedge clk);
    rst = 1'b1; bmem_rvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      rst = 1'b0; dfp_read = 1'b0;
      bmem_rvalid = (k < 2); bmem_rdata = {$urandom, $urandom};
      #1;
      chk_reset_outputs("midrst");
    end
    line = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    do_read(32'h0000_5000, line, 1, 4, 5, 7, 8);
    idle(1);

    // Randomized mix of reads and writes.
    for (int n = 0; n < 24; n++) begin
      addr = $urandom;
      line = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 1) == 1) begin
        do_write(addr, line, $urandom_range(0, 3));
      end else begin
        rd = $urandom_range(0, 3);
        t0 = 2 + rd + $urandom_range(0, 2);
        t1 = t0 + 1 + $urandom_range(0, 2);
        t2 = t1 + 1 + $urandom_range(0, 2);
        t3 = t2 + 1 + $urandom_range(0, 2);
        do_read(addr, line, rd, t0, t1, t2, t3);
      end
      idle($urandom_range(0, 2));
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
